shifter32_seq: RTL and testbench

Multi-cycle iterative 32-bit shifter that computes the same function as the combinational barrelshifter32, shifting one bit per clock. It is used in area-constrained datapaths and as a cycle-accurate cross-check target for barrelshifter32. Operands are accepted on a start pulse. A done pulse returns the result, which then holds until the next operation.

---
 rtl/shifter_pkg.sv | 17 +
 rtl/shifter32_seq_if.sv | 16 +
 rtl/shifter32_seq_shift_step.sv | 19 +
 rtl/shifter32_seq.sv | 74 +++++++
 tb/tb_shifter32_seq.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared constants for the serial shifter family: op codes, FSM encoding,
// default widths.
package shifter_pkg;
  localparam int W_DEFAULT   = 32;
  localparam int SHW_DEFAULT = 5;

  localparam logic [1:0] ALUC_SRA = 2'b00;
  localparam logic [1:0] ALUC_SRL = 2'b01;
  localparam logic [1:0] ALUC_SLA = 2'b10;
  localparam logic [1:0] ALUC_SLL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_e;
endpackage

// File: rtl/shifter32_seq_if.sv
// Request/result bundle for the iterative shifter; master issues, slave computes.
interface shifter32_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   b;
  logic [1:0]       aluc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] c;

  modport master (output start, a, b, aluc, input  busy, done, c);
  modport slave  (input  start, a, b, aluc, output busy, done, c);
endinterface

// File: rtl/shifter32_seq_shift_step.sv
// One-bit shift of sh by op; SLA and SLL are identical (zero fill on the right).
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = W_DEFAULT
) (
  input  logic [WIDTH-1:0] sh,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] sh_nxt
);
  always_comb begin
    sh_nxt = {sh[WIDTH-2:0], 1'b0};
    case (op)
      ALUC_SRA: sh_nxt = {sh[WIDTH-1], sh[WIDTH-1:1]};
      ALUC_SRL: sh_nxt = {1'b0, sh[WIDTH-1:1]};
      default:  sh_nxt = {sh[WIDTH-2:0], 1'b0};
    endcase
  end
endmodule

// File: rtl/shifter32_seq.sv
// Iterative shifter: captures operands on start, shifts one bit per clock,
// pulses done with the registered result, then holds c until the next done.
module shifter32_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = W_DEFAULT,
  parameter int SHW   = SHW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  shifter32_seq_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_step;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] c_q, c_d;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .sh     (sh_q),
    .op     (op_q),
    .sh_nxt (sh_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sh_d    = bus.a;
          cnt_d   = bus.b;
          op_d    = bus.aluc;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Result is latched on the way into FIN so c is valid with done.
        if (cnt_q == '0) begin
          c_d     = sh_q;
          state_d = ST_FIN;
        end else begin
          sh_d  = sh_step;
          cnt_d = cnt_q - SHW'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_FIN);
  assign bus.c    = c_q;
endmodule

// File: tb/tb_shifter32_seq.sv
// Directed bench for shifter32_seq: vector table, full op/amount sweep
// against a behavioural shifter, ignored-start and mid-op reset sequences.
module tb_shifter32_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  shifter32_seq_if #(.WIDTH(32), .SHW(5)) ifc ();

  shifter32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  aluc;
    logic [31:0] exp_c;
  } vec_t;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return $unsigned($signed(a) >>> b);
      2'b01:   return a >> b;
      default: return a << b;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_op(input string nm, input logic [31:0] a_i, input logic [4:0] b_i,
                        input logic [1:0] op_i, input logic [31:0] exp_c);
    int edges;
    int busy_n;
    logic [31:0] c_hold;
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = a_i; ifc.b = b_i; ifc.aluc = op_i;
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.a = ~a_i; ifc.b = ~b_i; ifc.aluc = ~op_i;
    edges = 0; busy_n = 0;
    while (!ifc.done && edges < 40) begin
      if (ifc.busy) busy_n++;
      @(posedge clk); #1;
      edges++;
    end
    check({nm, " latency"}, 32'(edges), 32'(b_i) + 32'd1);
    check({nm, " c"}, ifc.c, exp_c);
    check({nm, " busy_cycles"}, 32'(busy_n), 32'(b_i) + 32'd1);
    check({nm, " busy_at_done"}, 32'(ifc.busy), 32'd0);
    c_hold = ifc.c;
    @(posedge clk); #1;
    check({nm, " done_pulse"}, 32'(ifc.done), 32'd0);
    check({nm, " c_hold"}, ifc.c, exp_c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    int   edges, dones, done_edge;
    logic [31:0] c_at_done;

    vecs[0] = '{32'hA5F0C3E7, 5'd4,  2'b00, 32'hFA5F0C3E};
    vecs[1] = '{32'hA5F0C3E7, 5'd4,  2'b01, 32'h0A5F0C3E};
    vecs[2] = '{32'hA5F0C3E7, 5'd8,  2'b10, 32'hF0C3E700};
    vecs[3] = '{32'hA5F0C3E7, 5'd8,  2'b11, 32'hF0C3E700};
    vecs[4] = '{32'hA5F0C3E7, 5'd0,  2'b00, 32'hA5F0C3E7};
    vecs[5] = '{32'hA5F0C3E7, 5'd0,  2'b11, 32'hA5F0C3E7};
    vecs[6] = '{32'hA5F0C3E7, 5'd31, 2'b00, 32'hFFFFFFFF};
    vecs[7] = '{32'hA5F0C3E7, 5'd31, 2'b01, 32'h00000001};
    vecs[8] = '{32'hA5F0C3E7, 5'd31, 2'b11, 32'h80000000};

    ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.aluc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(ifc.busy), 32'd0);
    check("reset done", 32'(ifc.done), 32'd0);
    check("reset c", ifc.c, 32'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].aluc, vecs[i].exp_c);

    // Second start during SHIFT must not disturb the captured operands.
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = 32'h00000001; ifc.b = 5'd20; ifc.aluc = 2'b11;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    edges = 0; dones = 0; done_edge = 0; c_at_done = '0;
    repeat (30) begin
      @(posedge clk); #1;
      edges++;
      if (ifc.done) begin
        dones++;
        if (dones == 1) begin done_edge = edges; c_at_done = ifc.c; end
      end
      if (edges == 5) begin ifc.start = 1'b1; ifc.a = 32'hFFFFFFFF; end
      if (edges == 6) ifc.start = 1'b0;
    end
    check("ignored_start dones", 32'(dones), 32'd1);
    check("ignored_start latency", 32'(done_edge), 32'd21);
    check("ignored_start c", c_at_done, 32'h00100000);

    // Abort a long operation with an asynchronous reset.
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = 32'hA5F0C3E7; ifc.b = 5'd31; ifc.aluc = 2'b00;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort busy", 32'(ifc.busy), 32'd0);
    check("abort done", 32'(ifc.done), 32'd0);
    check("abort c", ifc.c, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op("rst_recover", 32'h00000002, 5'd1, 2'b01, 32'h00000001);

    for (int op = 0; op < 4; op++)
      for (int sh = 0; sh < 32; sh++)
        run_op($sformatf("sweep op%0d b%0d", op, sh), 32'hA5F0C3E7, 5'(sh), 2'(op),
               model(32'hA5F0C3E7, 5'(sh), 2'(op)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
